// File: rtl/sample_design_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sample_design_arbiter
// Description : Round-robin front end sharing one sample_design datapath;
//               results return in issue order via a tagged response FIFO.
// Revision    : 1.0
// ============================================================================
module sample_design_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int PIPE_LAT   = 1,
  parameter int RESP_DEPTH = 4,
  parameter int ID_W       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         dp_data_in,
  output logic                      dp_pipeline_en,
  input  logic [DATA_W-1:0]         dp_data_out,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  input  logic                      resp_ready,
  output logic                      busy
);

  localparam int c_PTR_W = $clog2(RESP_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(RESP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [DATA_W-1:0]   r_dp_data_in;
  logic                r_dp_pipeline_en;
  logic [PIPE_LAT:0]   r_tag_vld;
  logic [ID_W-1:0]     r_tag_id [PIPE_LAT+1];
  logic [c_CNT_W-1:0]  r_inflight;
  logic [c_CNT_W-1:0]  r_fifo_count;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [ID_W-1:0]     r_mem_id   [RESP_DEPTH];
  logic [DATA_W-1:0]   r_mem_data [RESP_DEPTH];

  logic                w_found;
  logic [ID_W-1:0]     w_grant_idx;
  logic [c_CNT_W:0]    w_used;
  logic                w_credit_ok;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found     = 1'b1;
        w_grant_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_used      = {1'b0, r_inflight} + {1'b0, r_fifo_count};
  assign w_credit_ok = (w_used < c_DEPTH);
  assign w_accept    = (r_state == RUN) && w_credit_ok && w_found;
  assign w_push      = r_tag_vld[PIPE_LAT];
  assign w_pop       = resp_valid && resp_ready;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_rr_ptr         <= ID_W'(NUM_REQ - 1);
      r_dp_data_in     <= '0;
      r_dp_pipeline_en <= 1'b0;
      r_tag_vld        <= '0;
      r_inflight       <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE:    if (enable) r_state <= RUN;
        RUN:     if (!enable) r_state <= DRAIN;
        DRAIN: begin
          if (enable)                r_state <= RUN;
          else if (r_inflight == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      r_dp_pipeline_en <= w_accept;
      if (w_accept) begin
        r_dp_data_in <= req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
        r_rr_ptr     <= w_grant_idx;
      end

      // Tag pipe mirrors the datapath register depth plus the issue register.
      r_tag_vld   <= {r_tag_vld[PIPE_LAT-1:0], w_accept};
      r_tag_id[0] <= w_grant_idx;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        r_tag_id[i] <= r_tag_id[i-1];
      end

      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_id[r_wr_ptr]   <= r_tag_id[PIPE_LAT];
        r_mem_data[r_wr_ptr] <= dp_data_out;
        r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + c_CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - c_CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Head fields are masked so stale storage never shows on an empty FIFO.
  assign resp_valid     = (r_fifo_count != '0);
  assign resp_id        = resp_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign resp_data      = resp_valid ? r_mem_data[r_rd_ptr] : '0;
  assign dp_data_in     = r_dp_data_in;
  assign dp_pipeline_en = r_dp_pipeline_en;
  assign busy           = (r_state != IDLE) || resp_valid;

endmodule
`default_nettype wire
